vector_strip_exec: RTL and testbench

- Multi-cycle vector execution unit: applies one element-wise ALU op to two vectors of up to VLEN elements, processing LANES elements per clock beat (strip-mining).
- Sits between the vector register read ports and the vector write-back mux of the vector CPU.
- Generalises the fixed four-lane datapath to parametrised lane count, vector length and active-length control, with a start/busy/done handshake.

---
 rtl/vector_pkg.sv | 22 ++
 rtl/vector_lane_alu.sv | 35 +++
 rtl/vector_strip_exec.sv | 160 ++++++++++++++++
 tb/tb_vector_strip_exec.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared types for the strip-mined vector execution unit.
// Op codes and FSM state encodings.
package vector_pkg;

  typedef enum logic [2:0] {
    VOP_ADD = 3'b000,
    VOP_SUB = 3'b001,
    VOP_AND = 3'b010,
    VOP_OR  = 3'b011,
    VOP_XOR = 3'b100,
    VOP_SLL = 3'b101,
    VOP_SRL = 3'b110,
    VOP_MUL = 3'b111
  } vop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vector_lane_alu.sv
// Single-element combinational ALU, one per lane.
// Unsigned, wraps mod 2^DATA_W; shifts use the low bits of b.
module vector_lane_alu
  import vector_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  vop_e              op,
  output logic [DATA_W-1:0] y
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] sh;
  assign sh = b[SH_W-1:0];

  // element-wise operation select
  always_comb begin
    y = '0;
    case (op)
      VOP_ADD: y = a + b;
      VOP_SUB: y = a - b;
      VOP_AND: y = a & b;
      VOP_OR:  y = a | b;
      VOP_XOR: y = a ^ b;
      VOP_SLL: y = a << sh;
      VOP_SRL: y = a >> sh;
      VOP_MUL: y = a * b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vector_strip_exec.sv
// Strip-mined vector execution unit: LANES elements per beat.
// Optional per-element mask when VEC_STRIP_MASK_EN is defined.
module vector_strip_exec
  import vector_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int VLEN   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2:0]                 op,
  input  logic                       vs_mode,
  input  logic [$clog2(VLEN+1)-1:0]  vl,
  input  logic [VLEN*DATA_W-1:0]     src_a,
  input  logic [VLEN*DATA_W-1:0]     src_b,
  input  logic [DATA_W-1:0]          scalar,
`ifdef VEC_STRIP_MASK_EN
  input  logic [VLEN-1:0]            vmask,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [VLEN*DATA_W-1:0]     result,
  output logic                       zero
);

  localparam int VL_W   = $clog2(VLEN+1);
  localparam int BEATS  = VLEN / LANES;
  localparam int BEAT_W = $clog2(BEATS+1);

  state_e                   state_q;
  vop_e                     op_q;
  logic                     vs_q;
  logic [VL_W-1:0]          vl_q;
  logic [VLEN*DATA_W-1:0]   a_q;
  logic [VLEN*DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]        s_q;
  logic [BEAT_W-1:0]        beat_q;
  logic                     busy_q;
  logic                     done_q;
  logic [VLEN*DATA_W-1:0]   result_q;
`ifdef VEC_STRIP_MASK_EN
  logic [VLEN-1:0]          m_q;
`endif

  logic [VL_W-1:0]   vl_eff;
  logic [VL_W-1:0]   lane_idx [LANES];
  logic [DATA_W-1:0] lane_y   [LANES];
  logic [VL_W:0]     nxt_base;
  logic              last_beat;

  // clamp requested length to the vector capacity
  always_comb begin
    vl_eff = vl;
    if (vl > VL_W'(VLEN)) vl_eff = VL_W'(VLEN);
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATA_W-1:0] la;
    logic [DATA_W-1:0] lb;
    logic [DATA_W-1:0] ly;

    assign lane_idx[l] = VL_W'(beat_q) * VL_W'(LANES) + VL_W'(l);
    assign la = a_q[lane_idx[l]*DATA_W +: DATA_W];
    assign lb = vs_q ? s_q : b_q[lane_idx[l]*DATA_W +: DATA_W];

    vector_lane_alu #(
      .DATA_W (DATA_W)
    ) u_alu (
      .a  (la),
      .b  (lb),
      .op (op_q),
      .y  (ly)
    );

`ifdef VEC_STRIP_MASK_EN
    assign lane_y[l] = (lane_idx[l] < vl_q)
                     ? (m_q[lane_idx[l]] ? ly : la)
                     : '0;
`else
    assign lane_y[l] = (lane_idx[l] < vl_q) ? ly : '0;
`endif
  end

  // this beat is the last once the next base reaches vl
  assign nxt_base  = {1'b0, lane_idx[0]} + (VL_W+1)'(LANES);
  assign last_beat = nxt_base >= {1'b0, vl_q};

  // control FSM, operand snapshot and result write-back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_q     <= VOP_ADD;
      vs_q     <= 1'b0;
      vl_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      beat_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef VEC_STRIP_MASK_EN
      m_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q     <= vop_e'(op);
            vs_q     <= vs_mode;
            vl_q     <= vl_eff;
            a_q      <= src_a;
            b_q      <= src_b;
            s_q      <= scalar;
            beat_q   <= '0;
            busy_q   <= 1'b1;
            result_q <= '0;
`ifdef VEC_STRIP_MASK_EN
            m_q      <= vmask;
`endif
            if (vl_eff == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          for (int l = 0; l < LANES; l++) begin
            result_q[lane_idx[l]*DATA_W +: DATA_W] <= lane_y[l];
          end
          beat_q <= beat_q + 1'b1;
          if (last_beat) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = ~|result_q;

endmodule

// File: tb/tb_vector_strip_exec.sv
// Scoreboard bench for vector_strip_exec.
// Build with VEC_STRIP_MASK_EN to add the mask case.
module tb_vector_strip_exec;

  localparam int DW = 32;
  localparam int LN = 4;
  localparam int VL = 16;
  localparam int VW = VL * DW;

  typedef logic [VW-1:0] vec_t;
  typedef struct {
    vec_t res;
    logic z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        vs_mode = 1'b0;
  logic [4:0]  vl = 5'd0;
  vec_t        src_a = '0;
  vec_t        src_b = '0;
  logic [DW-1:0] scalar = '0;
`ifdef VEC_STRIP_MASK_EN
  logic [VL-1:0] vmask = '1;
`endif
  logic        busy;
  logic        done;
  vec_t        result;
  logic        zero;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_done = 0;

  always #5 clk = ~clk;

  vector_strip_exec #(
    .DATA_W (DW),
    .LANES  (LN),
    .VLEN   (VL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .vs_mode (vs_mode),
    .vl      (vl),
    .src_a   (src_a),
    .src_b   (src_b),
    .scalar  (scalar),
`ifdef VEC_STRIP_MASK_EN
    .vmask   (vmask),
`endif
    .busy    (busy),
    .done    (done),
    .result  (result),
    .zero    (zero)
  );

  function automatic void check(string nm, vec_t got, vec_t want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, want);
  endfunction

  // elements i<n get base+i*step, the rest zero
  function automatic vec_t fill(int n, logic [DW-1:0] base,
                                logic [DW-1:0] step);
    vec_t v = '0;
    for (int i = 0; i < n; i++) v[i*DW +: DW] = base + DW'(i) * step;
    return v;
  endfunction

  // monitor: every done pulse pops and compares one expectation
  always @(negedge clk) begin
    if (rst && done) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got 1 want 0");
      end else begin
        e = q.pop_front();
        check("result", result, e.res);
        check("zero", vec_t'(zero), vec_t'(e.z));
      end
    end
  end

  task automatic run_op(string nm, logic [2:0] o, logic vsm,
                        logic [4:0] v, vec_t a, vec_t b,
                        logic [DW-1:0] s, vec_t ex, int lat_exp,
                        bit poke);
    exp_t e;
    int lat = 0;
    int bsy = 0;
    int d0;
    bit got = 0;
    e.res = ex;
    e.z   = (ex == '0);
    q.push_back(e);
    d0 = n_done;
    @(negedge clk);
    op = o; vs_mode = vsm; vl = v;
    src_a = a; src_b = b; scalar = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = ~o; vs_mode = ~vsm; vl = ~v;
    src_a = ~a; src_b = ~b; scalar = ~s;
    if (poke) begin
      fork
        begin
          @(negedge clk);
          start = 1'b1;
          repeat (2) @(negedge clk);
          start = 1'b0;
        end
      join_none
    end
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bsy++;
      if (done) got = 1;
    end
    check({nm, "_latency"}, vec_t'(lat), vec_t'(lat_exp));
    check({nm, "_busy_cycles"}, vec_t'(bsy), vec_t'(lat_exp));
    @(negedge clk);
    check({nm, "_idle_after"}, vec_t'(busy), vec_t'(0));
    check({nm, "_done_count"}, vec_t'(n_done - d0), vec_t'(1));
  endtask

  initial begin
    vec_t ex;
    int d0;
    #12;
    check("rst_busy", vec_t'(busy), vec_t'(0));
    check("rst_done", vec_t'(done), vec_t'(0));
    check("rst_result", result, '0);
    check("rst_zero", vec_t'(zero), vec_t'(1));
    @(negedge clk);
    rst = 1'b1;

    run_op("add_full", 3'b000, 1'b0, 5'd16,
           fill(16, 0, 1), fill(16, 100, 0), 0,
           fill(16, 100, 1), 5, 1'b1);

    run_op("sub_tail", 3'b001, 1'b0, 5'd6,
           fill(16, 10, 0), fill(16, 3, 0), 0,
           fill(6, 7, 0), 3, 1'b0);

    run_op("add_scalar", 3'b000, 1'b1, 5'd16,
           fill(16, 32'hFFFF_FFFF, 0), fill(16, 55, 0), 32'h2,
           fill(16, 32'h1, 0), 5, 1'b0);

    run_op("mul_scalar", 3'b111, 1'b1, 5'd16,
           fill(16, 32'hFFFF_FFFF, 0), fill(16, 55, 0), 32'h2,
           fill(16, 32'hFFFF_FFFE, 0), 5, 1'b0);

    run_op("vl_zero", 3'b000, 1'b0, 5'd0,
           fill(16, 9, 1), fill(16, 4, 0), 0,
           '0, 1, 1'b0);

    ex = '0;
    for (int i = 0; i < 16; i++) ex[i*DW +: DW] = DW'(i ^ 1);
    run_op("vl_clamp", 3'b100, 1'b0, 5'd20,
           fill(16, 0, 1), fill(16, 1, 0), 0, ex, 5, 1'b0);

    ex = '0;
    for (int i = 0; i < 4; i++) ex[i*DW +: DW] = 32'h1 << i;
    run_op("sll", 3'b101, 1'b0, 5'd4,
           fill(16, 1, 0), fill(16, 32, 1), 0, ex, 2, 1'b0);

    ex = '0;
    for (int i = 0; i < 8; i++) ex[i*DW +: DW] = 32'h8000_0000 >> i;
    run_op("srl", 3'b110, 1'b0, 5'd8,
           fill(16, 32'h8000_0000, 0), fill(16, 0, 1), 0, ex, 3, 1'b0);

    ex = '0;
    for (int i = 0; i < 5; i++) ex[i*DW +: DW] = 32'hF0 | DW'(i);
    run_op("or", 3'b011, 1'b0, 5'd5,
           fill(16, 32'hF0, 0), fill(16, 0, 1), 0, ex, 3, 1'b0);

    ex = '0;
    for (int i = 0; i < 16; i++) ex[i*DW +: DW] = DW'(i & 3);
    run_op("and", 3'b010, 1'b0, 5'd16,
           fill(16, 0, 1), fill(16, 3, 0), 0, ex, 5, 1'b0);

`ifdef VEC_STRIP_MASK_EN
    vmask = 16'h00FF;
    ex = '0;
    for (int i = 0; i < 8; i++) ex[i*DW +: DW] = 32'd6;
    for (int i = 8; i < 12; i++) ex[i*DW +: DW] = 32'd5;
    run_op("mask_xor", 3'b100, 1'b0, 5'd12,
           fill(16, 5, 0), fill(16, 3, 0), 0, ex, 4, 1'b0);
    vmask = '1;
`endif

    // abort a full-length add after two beats
    d0 = n_done;
    @(negedge clk);
    op = 3'b000; vs_mode = 1'b0; vl = 5'd16;
    src_a = fill(16, 1, 1); src_b = fill(16, 1, 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", vec_t'(busy), vec_t'(0));
    check("abort_done", vec_t'(done), vec_t'(0));
    check("abort_result", result, '0);
    check("abort_zero", vec_t'(zero), vec_t'(1));
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_done", vec_t'(n_done - d0), vec_t'(0));
    check("abort_hold", result, '0);
    check("scoreboard_empty", vec_t'(q.size()), vec_t'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
